// File: rtl/mips32_arb_pkg.sv
// Shared types and constants for the MIPS32 unified-memory arbiter.
// Contents: FSM state enum, requester/owner enum, data word width,
// default word-address width and one-hot winner bit positions.
package mips32_arb_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned DEFAULT_AW = 10;

    // One-hot winner vector layout produced by the priority picker
    localparam int unsigned WIN_W  = 3;
    localparam int unsigned WIN_IF = 0;
    localparam int unsigned WIN_DM = 1;
    localparam int unsigned WIN_LD = 2;

    typedef enum logic {
        ARB_IDLE,
        ARB_WAIT_RD
    } arb_state_e;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_IF,
        REQ_DM,
        REQ_LD
    } req_e;

endpackage

// File: rtl/mips32_arb_prio.sv
// Combinational priority picker for the unified-memory arbiter.
// Ports:
//   if_req, dm_req, ld_req : raw requests
//   halted_i               : core halted, enables the loader
//   starve_sat             : IF has been denied long enough to be promoted
//   winner                 : one-hot {LD, DM, IF}, all-zero when nobody asks
module mips32_arb_prio
    import mips32_arb_pkg::*;
(
    input  logic             if_req,
    input  logic             dm_req,
    input  logic             ld_req,
    input  logic             halted_i,
    input  logic             starve_sat,
    output logic [WIN_W-1:0] winner
);

    // Loader first, then a starved IF, then DM, then IF
    always_comb begin
        winner = '0;
        if (halted_i && ld_req) begin
            winner[WIN_LD] = 1'b1;
        end else if (if_req && starve_sat) begin
            winner[WIN_IF] = 1'b1;
        end else if (dm_req) begin
            winner[WIN_DM] = 1'b1;
        end else if (if_req) begin
            winner[WIN_IF] = 1'b1;
        end
    end

endmodule

// File: rtl/mips32_mem_arbiter.sv
// Single-ported unified-memory arbiter for the MIPS32 pipelined core.
// Shares one word-addressed memory between instruction fetch (IF), data
// access (DM) and a program loader (LD, only while halted). One read may
// be outstanding; writes complete in the grant cycle.
// Ports:
//   clk1, reset              : clock, synchronous active-high reset
//   halted_i                 : core halted, enables the LD port
//   if_*                     : IF read request / grant / response
//   dm_*                     : DM load/store request / grant / response
//   ld_*                     : loader write request / grant
//   mem_*                    : memory macro interface (read data RD_LAT later)
//   busy                     : a read is in flight
//   stat_if_wait/stat_dm_wait: wait-cycle counters
// Build option: define MEM_ARB_STATS_EN to implement the wait-cycle
// counters; otherwise both stat outputs are tied to zero.
module mips32_mem_arbiter
    import mips32_arb_pkg::*;
#(
    parameter int unsigned AW         = DEFAULT_AW,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk1,
    input  logic              reset,
    input  logic              halted_i,
    input  logic              if_req,
    input  logic [AW-1:0]     if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [WORD_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [AW-1:0]     dm_addr,
    input  logic [WORD_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [WORD_W-1:0] dm_rdata,
    input  logic              ld_req,
    input  logic [AW-1:0]     ld_addr,
    input  logic [WORD_W-1:0] ld_wdata,
    output logic              ld_gnt,
    output logic              mem_en,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              busy,
    output logic [15:0]       stat_if_wait,
    output logic [15:0]       stat_dm_wait
);

    localparam int unsigned CW = 3;
    localparam int unsigned SW = $clog2(STARVE_MAX + 2);

    arb_state_e       state, state_nxt;
    req_e             owner, owner_nxt;
    logic [CW-1:0]    rd_cnt, rd_cnt_nxt;
    logic [SW-1:0]    starve, starve_nxt;
    logic             starve_sat;
    logic [WIN_W-1:0] winner;
    logic             if_rvalid_nxt, dm_rvalid_nxt;

    assign starve_sat = (starve == SW'(STARVE_MAX));
    assign busy       = (state != ARB_IDLE);

    mips32_arb_prio u_prio (
        .if_req     (if_req),
        .dm_req     (dm_req),
        .ld_req     (ld_req),
        .halted_i   (halted_i),
        .starve_sat (starve_sat),
        .winner     (winner)
    );

    // Next-state, grants and memory strobe; everything is quiet in reset
    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        rd_cnt_nxt    = rd_cnt;
        starve_nxt    = starve;
        if_rvalid_nxt = 1'b0;
        dm_rvalid_nxt = 1'b0;
        if_gnt        = 1'b0;
        dm_gnt        = 1'b0;
        ld_gnt        = 1'b0;
        mem_en        = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;

        if (!reset) begin
            case (state)
                ARB_IDLE: begin
                    if (winner[WIN_LD]) begin
                        ld_gnt    = 1'b1;
                        mem_en    = 1'b1;
                        mem_we    = 1'b1;
                        mem_addr  = ld_addr;
                        mem_wdata = ld_wdata;
                    end else if (winner[WIN_DM]) begin
                        dm_gnt    = 1'b1;
                        mem_en    = 1'b1;
                        mem_we    = dm_we;
                        mem_addr  = dm_addr;
                        mem_wdata = dm_wdata;
                        if (!dm_we) begin
                            state_nxt  = ARB_WAIT_RD;
                            owner_nxt  = REQ_DM;
                            rd_cnt_nxt = CW'(RD_LAT);
                        end
                    end else if (winner[WIN_IF]) begin
                        if_gnt     = 1'b1;
                        mem_en     = 1'b1;
                        mem_addr   = if_addr;
                        state_nxt  = ARB_WAIT_RD;
                        owner_nxt  = REQ_IF;
                        rd_cnt_nxt = CW'(RD_LAT);
                    end

                    // Only arbitration cycles count as IF starvation
                    if (if_req && !if_gnt && !starve_sat) begin
                        starve_nxt = starve + SW'(1);
                    end
                end
                ARB_WAIT_RD: begin
                    rd_cnt_nxt = rd_cnt - CW'(1);
                    // Data is on mem_rdata in the last countdown cycle
                    if (rd_cnt == CW'(1)) begin
                        if_rvalid_nxt = (owner == REQ_IF);
                        dm_rvalid_nxt = (owner == REQ_DM);
                        owner_nxt     = REQ_NONE;
                        state_nxt     = ARB_IDLE;
                    end
                end
                default: begin
                    state_nxt = ARB_IDLE;
                end
            endcase

            if (!if_req || if_gnt) begin
                starve_nxt = '0;
            end
        end
    end

    // State, owner, counters and the registered read responses
    always_ff @(posedge clk1) begin
        if (reset) begin
            state     <= ARB_IDLE;
            owner     <= REQ_NONE;
            rd_cnt    <= '0;
            starve    <= '0;
            if_rvalid <= 1'b0;
            dm_rvalid <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            rd_cnt    <= rd_cnt_nxt;
            starve    <= starve_nxt;
            if_rvalid <= if_rvalid_nxt;
            dm_rvalid <= dm_rvalid_nxt;
            if (if_rvalid_nxt) begin
                if_rdata <= mem_rdata;
            end
            if (dm_rvalid_nxt) begin
                dm_rdata <= mem_rdata;
            end
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [15:0] if_wait_q, dm_wait_q;

    // Saturating wait-cycle counters, busy cycles included
    always_ff @(posedge clk1) begin
        if (reset) begin
            if_wait_q <= '0;
            dm_wait_q <= '0;
        end else begin
            if (if_req && !if_gnt && (if_wait_q != 16'hFFFF)) begin
                if_wait_q <= if_wait_q + 16'd1;
            end
            if (dm_req && !dm_gnt && (dm_wait_q != 16'hFFFF)) begin
                dm_wait_q <= dm_wait_q + 16'd1;
            end
        end
    end

    assign stat_if_wait = if_wait_q;
    assign stat_dm_wait = dm_wait_q;
`else
    assign stat_if_wait = '0;
    assign stat_dm_wait = '0;
`endif

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Self-checking bench for mips32_mem_arbiter: directed scenarios followed
// by randomized traffic. A memory model answers reads; a rule-based
// reference predicts grants, busy, memory strobes and read responses.
module tb_mips32_mem_arbiter;

    localparam int unsigned AW         = 10;
    localparam int unsigned RD_LAT     = 1;
    localparam int unsigned STARVE_MAX = 4;
    localparam int unsigned DEPTH      = 1 << AW;

    logic          clk1;
    logic          reset;
    logic          halted_i;
    logic          if_req, dm_req, dm_we, ld_req;
    logic [AW-1:0] if_addr, dm_addr, ld_addr;
    logic [31:0]   dm_wdata, ld_wdata;
    logic          if_gnt, dm_gnt, ld_gnt;
    logic          if_rvalid, dm_rvalid;
    logic [31:0]   if_rdata, dm_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;
    logic          busy;
    logic [15:0]   stat_if_wait, stat_dm_wait;

    mips32_mem_arbiter #(
        .AW(AW), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk1(clk1), .reset(reset), .halted_i(halted_i),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .stat_if_wait(stat_if_wait), .stat_dm_wait(stat_dm_wait)
    );

    typedef struct {
        logic [31:0] data;
        int          due;
    } rd_exp_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    rd_exp_t     if_q[$];
    rd_exp_t     dm_q[$];
    logic [31:0] ref_mem [DEPTH];
    int          rd_start = 0;
    int          rd_end = 0;
    int          m_starve = 0;
    int          m_if_wait = 0;
    int          m_dm_wait = 0;
    logic        g_if = 1'b0, g_dm = 1'b0, g_ld = 1'b0;

    initial begin
        clk1 = 1'b0;
        forever #5 clk1 = ~clk1;
    end

    always @(posedge clk1) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E3779B9) ^ 32'h13579BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    // Memory macro: write on strobe, read data appears RD_LAT cycles later
    initial begin
        logic [31:0] mem_arr [DEPTH];
        logic [31:0] rd_pipe [RD_LAT];
        for (int i = 0; i < int'(DEPTH); i++) mem_arr[i] = init_word(i);
        for (int i = 0; i < int'(RD_LAT); i++) rd_pipe[i] = 32'hDEADBEEF;
        mem_rdata = 32'hDEADBEEF;
        forever begin
            @(posedge clk1);
            for (int i = int'(RD_LAT) - 1; i > 0; i--) rd_pipe[i] = rd_pipe[i-1];
            rd_pipe[0] = (mem_en && !mem_we) ? mem_arr[mem_addr] : 32'hDEADBEEF;
            mem_rdata <= rd_pipe[RD_LAT-1];
            if (mem_en && mem_we) mem_arr[mem_addr] = mem_wdata;
        end
    end

    // Reference: predict this cycle's grant from the arbitration rules
    always @(negedge clk1) begin
        logic idle_e, e_if, e_dm, e_ld, e_any;
        idle_e = !((cyc > rd_start) && (cyc < rd_end));
        e_if = 1'b0; e_dm = 1'b0; e_ld = 1'b0;
        if (!reset && idle_e) begin
            if (halted_i && ld_req)                              e_ld = 1'b1;
            else if (if_req && m_starve == int'(STARVE_MAX))     e_if = 1'b1;
            else if (dm_req)                                     e_dm = 1'b1;
            else if (if_req)                                     e_if = 1'b1;
        end
        e_any = e_if | e_dm | e_ld;

        chk("gnt{ld,dm,if}", 32'({ld_gnt, dm_gnt, if_gnt}), 32'({e_ld, e_dm, e_if}));
        chk("busy", 32'(busy), 32'(!idle_e));
        chk("mem_en", 32'(mem_en), 32'(e_any));
        if (e_any) begin
            chk("mem_we", 32'(mem_we), 32'(e_ld | (e_dm & dm_we)));
            chk("mem_addr", 32'(mem_addr), e_ld ? 32'(ld_addr) : e_dm ? 32'(dm_addr) : 32'(if_addr));
        end
        if (e_ld)          chk("mem_wdata_ld", mem_wdata, ld_wdata);
        if (e_dm && dm_we) chk("mem_wdata_dm", mem_wdata, dm_wdata);
        if (reset) begin
            chk("mem_addr_rst", 32'(mem_addr), 32'd0);
            chk("mem_wdata_rst", mem_wdata, 32'd0);
        end
`ifdef MEM_ARB_STATS_EN
        chk("stat_if_wait", 32'(stat_if_wait), 32'(m_if_wait));
        chk("stat_dm_wait", 32'(stat_dm_wait), 32'(m_dm_wait));
`else
        chk("stat_if_wait", 32'(stat_if_wait), 32'd0);
        chk("stat_dm_wait", 32'(stat_dm_wait), 32'd0);
`endif

        if (reset) begin
            if_q.delete();
            dm_q.delete();
            rd_end = 0;
            m_starve = 0;
            m_if_wait = 0;
            m_dm_wait = 0;
        end else begin
            if (e_ld) ref_mem[ld_addr] = ld_wdata;
            if (e_dm && dm_we) ref_mem[dm_addr] = dm_wdata;
            if (e_if) if_q.push_back('{ref_mem[if_addr], cyc + int'(RD_LAT) + 1});
            if (e_dm && !dm_we) dm_q.push_back('{ref_mem[dm_addr], cyc + int'(RD_LAT) + 1});
            if (e_if || (e_dm && !dm_we)) begin
                rd_start = cyc;
                rd_end = cyc + int'(RD_LAT) + 1;
            end
            if (!if_req || e_if)                                     m_starve = 0;
            else if (idle_e && m_starve < int'(STARVE_MAX))          m_starve++;
            if (if_req && !e_if && m_if_wait < 65535) m_if_wait++;
            if (dm_req && !e_dm && m_dm_wait < 65535) m_dm_wait++;
        end
        g_if = if_gnt;
        g_dm = dm_gnt;
        g_ld = ld_gnt;
    end

    // Monitor: read responses must match the scoreboard in data and timing
    always @(negedge clk1) begin
        logic exp_if, exp_dm;
        exp_if = (if_q.size() > 0) && (if_q[0].due == cyc);
        exp_dm = (dm_q.size() > 0) && (dm_q[0].due == cyc);
        chk("if_rvalid", 32'(if_rvalid), 32'(exp_if));
        chk("dm_rvalid", 32'(dm_rvalid), 32'(exp_dm));
        if (exp_if) begin
            if (if_rvalid) chk("if_rdata", if_rdata, if_q[0].data);
            void'(if_q.pop_front());
        end
        if (exp_dm) begin
            if (dm_rvalid) chk("dm_rdata", dm_rdata, dm_q[0].data);
            void'(dm_q.pop_front());
        end
    end

    initial begin
        int n_dm;
        logic got_if;
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = init_word(i);
        reset = 1'b1; halted_i = 1'b0;
        if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; ld_req = 1'b0;
        if_addr = '0; dm_addr = '0; ld_addr = '0; dm_wdata = '0; ld_wdata = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Loader fills words 0..8 on consecutive cycles while halted
        halted_i = 1'b1;
        ld_req = 1'b1;
        for (int k = 0; k < 9; k++) begin
            ld_addr = AW'(k);
            ld_wdata = (k == 0) ? 32'h2801000a : (k == 5) ? 32'h00222000 : (32'h10000000 | 32'(k));
            tick();
            chk("ld_gnt_seq", 32'(g_ld), 32'd1);
        end
        ld_req = 1'b0;
        halted_i = 1'b0;
        tick();

        // Single instruction fetch from word 5
        if_req = 1'b1; if_addr = AW'(5);
        tick();
        chk("if_gnt_single", 32'(g_if), 32'd1);
        if_req = 1'b0;
        repeat (4) tick();

        // IF and DM loads contending: DM wins until IF is promoted
        if_req = 1'b1; if_addr = AW'(7);
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = AW'(2);
        n_dm = 0; got_if = 1'b0;
        for (int k = 0; k < 60 && !got_if; k++) begin
            tick();
            if (g_if) got_if = 1'b1;
            else if (g_dm) n_dm++;
        end
        chk("starve_if_granted", 32'(got_if), 32'd1);
        chk("starve_dm_grants", 32'(n_dm), 32'(STARVE_MAX));
        if_req = 1'b0; dm_req = 1'b0;
        repeat (4) tick();

        // Store then load the same word back to back
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = AW'(3); dm_wdata = 32'hCAFE0003;
        tick();
        chk("dm_store_gnt", 32'(g_dm), 32'd1);
        dm_we = 1'b0;
        tick();
        chk("dm_load_gnt", 32'(g_dm), 32'd1);
        dm_req = 1'b0;
        repeat (4) tick();

        // Reset right after a read grant abandons the read
        if_req = 1'b1; if_addr = AW'(2);
        tick();
        chk("if_gnt_pre_reset", 32'(g_if), 32'd1);
        if_req = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0; if_req = 1'b1; if_addr = AW'(4);
        tick();
        chk("if_gnt_after_reset", 32'(g_if), 32'd1);
        if_req = 1'b0;
        repeat (4) tick();

        // IF waits behind four DM stores
        reset = 1'b1;
        tick();
        reset = 1'b0;
        if_req = 1'b1; if_addr = AW'(6);
        dm_req = 1'b1; dm_we = 1'b1;
        for (int k = 0; k < 4; k++) begin
            dm_addr = AW'(10 + k); dm_wdata = 32'hA0000000 | 32'(k);
            tick();
            chk("dm_store_burst_gnt", 32'(g_dm), 32'd1);
        end
        dm_req = 1'b0;
        tick();
        chk("if_gnt_after_burst", 32'(g_if), 32'd1);
        if_req = 1'b0;
        repeat (3) tick();
`ifdef MEM_ARB_STATS_EN
        chk("stat_if_wait_burst", 32'(stat_if_wait), 32'd4);
`else
        chk("stat_if_wait_burst", 32'(stat_if_wait), 32'd0);
`endif

        // Randomized traffic; each requester holds its request until granted
        for (int n = 0; n < 2000; n++) begin
            if (n % 64 == 0) halted_i = ($urandom_range(0, 3) == 0);
            if (!if_req || g_if) begin
                if_req = ($urandom_range(0, 2) != 0);
                if_addr = AW'($urandom_range(0, 15));
            end
            if (!dm_req || g_dm) begin
                dm_req = ($urandom_range(0, 2) != 0);
                dm_we = 1'($urandom_range(0, 1));
                dm_addr = AW'($urandom_range(0, 15));
                dm_wdata = $urandom;
            end
            if (!ld_req || g_ld) begin
                ld_req = ($urandom_range(0, 3) == 0);
                ld_addr = AW'($urandom_range(0, 15));
                ld_wdata = $urandom;
            end
            tick();
        end
        if_req = 1'b0; dm_req = 1'b0; ld_req = 1'b0; halted_i = 1'b0;

        for (int k = 0; k < 50 && (if_q.size() + dm_q.size()) != 0; k++) tick();
        chk("responses_drained", 32'(if_q.size() + dm_q.size()), 32'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
